// File: rtl/sr_reg_dump_pkg.sv
// sr_reg_dump_pkg: shared constants and types for the debug register dump.
//   SR_DUMP_SYNC_DEFAULT : default frame header byte
//   SR_DUMP_REC_BYTES    : bytes per record (address byte + 4 data bytes)
//   dumpState_e          : dump FSM state encoding (3-bit)
package sr_reg_dump_pkg;

    localparam logic [7:0] SR_DUMP_SYNC_DEFAULT = 8'hA5;
    localparam int         SR_DUMP_REC_BYTES    = 5;
    // Index of the final byte within a record.
    localparam logic [2:0] SR_DUMP_LAST_IDX     = 3'(SR_DUMP_REC_BYTES - 1);

    typedef enum logic [2:0] {
        SR_DUMP_IDLE    = 3'd0,
        SR_DUMP_SYNC    = 3'd1,
        SR_DUMP_CAPTURE = 3'd2,
        SR_DUMP_SEND    = 3'd3,
        SR_DUMP_DONE    = 3'd4
    } dumpState_e;

endpackage

// File: rtl/sr_reg_dump_if.sv
// sr_reg_dump_if: debug register port plus the outgoing byte stream.
//   regAddr/regData : address to the CPU debug port, combinational data back
//   txData/txValid  : byte stream towards the UART TX or a monitor
//   txReady         : sink accepts the byte this cycle
// master = dump engine side, slave = CPU + byte sink side.
interface sr_reg_dump_if;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;

    modport master (output regAddr, txData, txValid,
                    input  regData, txReady);
    modport slave  (input  regAddr, txData, txValid,
                    output regData, txReady);
endinterface

// File: rtl/sr_dump_shifter.sv
// sr_dump_shifter: holds one 40-bit record {data, addrByte} and serves it
// one byte at a time, address byte first, then data LSB first.
//   load    : capture regData and {3'b000, regAddr}, restart at byte 0
//   shift   : current byte was accepted, advance to the next
//   recByte : byte currently presented
//   last    : the presented byte is the final byte of the record
module sr_dump_shifter
    import sr_reg_dump_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        shift,
    input  logic [31:0] regData,
    input  logic [4:0]  regAddr,
    output logic [7:0]  recByte,
    output logic        last
);

    logic [39:0] rec;
    logic [2:0]  cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec <= '0;
            cnt <= '0;
        end else if (load) begin
            rec <= {regData, 3'b000, regAddr};
            cnt <= '0;
        end else if (shift) begin
            cnt <= cnt + 3'd1;
        end
    end

    // Explicit mux keeps the counter from ever selecting past bit 39.
    always_comb begin
        recByte = rec[7:0];
        case (cnt)
            3'd1:    recByte = rec[15:8];
            3'd2:    recByte = rec[23:16];
            3'd3:    recByte = rec[31:24];
            3'd4:    recByte = rec[39:32];
            default: recByte = rec[7:0];
        endcase
    end

    assign last = (cnt == SR_DUMP_LAST_IDX);

endmodule

// File: rtl/sr_reg_dump.sv
// sr_reg_dump: on start, walks debug addresses FIRST_REG..LAST_REG, samples
// each live 32-bit value and streams a framed byte sequence:
//   SYNC_BYTE, then per register: addr, d[7:0], d[15:8], d[23:16], d[31:24].
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : dump request, only looked at in IDLE
//   busy       : dump in progress
//   done       : one-cycle pulse after the last byte is accepted
//   dbg        : debug register port + byte stream (master side)
module sr_reg_dump
    import sr_reg_dump_pkg::*;
#(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31,
    parameter logic [7:0]  SYNC_BYTE = SR_DUMP_SYNC_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    sr_reg_dump_if.master  dbg
);

    localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
    localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

    if (FIRST_REG > LAST_REG || LAST_REG > 31) begin : gBadRange
        $error("sr_reg_dump: need FIRST_REG <= LAST_REG <= 31");
    end

    dumpState_e state;
    logic [4:0] regAddr;
    logic       txValid;
    logic [7:0] recByte;
    logic       recLast;
    logic       xfer;

    assign xfer = txValid && dbg.txReady;

    sr_dump_shifter uShifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state == SR_DUMP_CAPTURE),
        .shift   ((state == SR_DUMP_SEND) && xfer),
        .regData (dbg.regData),
        .regAddr (regAddr),
        .recByte (recByte),
        .last    (recLast)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SR_DUMP_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            txValid <= 1'b0;
            regAddr <= FIRST_ADDR;
        end else begin
            done <= 1'b0;
            case (state)
                SR_DUMP_IDLE: if (start) begin
                    state   <= SR_DUMP_SYNC;
                    busy    <= 1'b1;
                    txValid <= 1'b1;
                    regAddr <= FIRST_ADDR;
                end
                SR_DUMP_SYNC: if (xfer) begin
                    state   <= SR_DUMP_CAPTURE;
                    txValid <= 1'b0;
                end
                // regAddr has been stable a full cycle here, so regData is settled.
                SR_DUMP_CAPTURE: begin
                    state   <= SR_DUMP_SEND;
                    txValid <= 1'b1;
                end
                SR_DUMP_SEND: if (xfer && recLast) begin
                    txValid <= 1'b0;
                    // Compare before incrementing: LAST_REG=31 never wraps to 0.
                    if (regAddr == LAST_ADDR) begin
                        state <= SR_DUMP_DONE;
                        done  <= 1'b1;
                    end else begin
                        regAddr <= regAddr + 5'd1;
                        state   <= SR_DUMP_CAPTURE;
                    end
                end
                // start is deliberately not looked at here.
                SR_DUMP_DONE: begin
                    busy    <= 1'b0;
                    regAddr <= FIRST_ADDR;
                    state   <= SR_DUMP_IDLE;
                end
                default: state <= SR_DUMP_IDLE;
            endcase
        end
    end

    // Byte mux over registered state; stays stable while stalled.
    always_comb begin
        dbg.txData = 8'h00;
        case (state)
            SR_DUMP_SYNC: dbg.txData = SYNC_BYTE;
            SR_DUMP_SEND: dbg.txData = recByte;
            default:      dbg.txData = 8'h00;
        endcase
    end

    assign dbg.txValid = txValid;
    assign dbg.regAddr = regAddr;

endmodule

// File: tb/tb_sr_reg_dump.sv
// tb_sr_reg_dump: scoreboard bench. Expected frames are built from the
// register contents and pushed into queues; monitors pop on each transfer.
module tb_sr_reg_dump;
    logic clk = 1'b0;
    logic rst_n;
    logic startA, startB;
    logic busyA, doneA, busyB, doneB;
    logic randReady;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] regsA [32];
    logic [31:0] regsB [32];
    logic [7:0]  expQA [$];
    logic [7:0]  expQB [$];
    int popCntA = 0, doneCntA = 0, lastPopA = 0;
    int popCntB = 0, doneCntB = 0, lastPopB = 0;

    sr_reg_dump_if ifA ();
    sr_reg_dump_if ifB ();

    sr_reg_dump dutA (.clk(clk), .rst_n(rst_n), .start(startA),
                      .busy(busyA), .done(doneA), .dbg(ifA));
    sr_reg_dump #(.FIRST_REG(5), .LAST_REG(5)) dutB (
                      .clk(clk), .rst_n(rst_n), .start(startB),
                      .busy(busyB), .done(doneB), .dbg(ifB));

    // CPU models: combinational read of a register file.
    assign ifA.regData = regsA[ifA.regAddr];
    assign ifB.regData = regsB[ifB.regAddr];
    assign ifB.txReady = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // txReady driver: always high, or ~30% high when randReady is set.
    initial begin
        ifA.txReady = 1'b1;
        forever begin
            @(posedge clk);
            #1 ifA.txReady = randReady ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    // Monitor A: handshake rules, byte scoreboard, done timing.
    logic       stallA = 1'b0, donePrevA = 1'b0;
    logic [7:0] heldA = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            stallA    = 1'b0;
            donePrevA = 1'b0;
        end else begin
            if (stallA) begin
                chk("A_hold_valid", ifA.txValid, 1);
                if (ifA.txValid) chk("A_hold_data", ifA.txData, heldA);
            end
            if (ifA.txValid) chk("A_busy_while_valid", busyA, 1);
            if (ifA.txValid && ifA.txReady) begin
                if (expQA.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL A_unexpected_byte actual=%0h required=none", ifA.txData);
                end else begin
                    chk("A_byte", ifA.txData, expQA.pop_front());
                end
                popCntA++;
                lastPopA = cyc;
            end
            if (doneA) begin
                doneCntA++;
                chk("A_done_after_last", cyc, lastPopA + 1);
                chk("A_queue_empty_at_done", expQA.size(), 0);
                chk("A_done_single", donePrevA, 0);
            end
            donePrevA = doneA;
            stallA = ifA.txValid && !ifA.txReady;
            heldA  = ifA.txData;
        end
    end

    // Monitor B: single-record configuration.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifB.txValid) begin
                if (expQB.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL B_unexpected_byte actual=%0h required=none", ifB.txData);
                end else begin
                    chk("B_byte", ifB.txData, expQB.pop_front());
                end
                popCntB++;
                lastPopB = cyc;
            end
            if (doneB) begin
                doneCntB++;
                chk("B_done_after_last", cyc, lastPopB + 1);
                chk("B_queue_empty_at_done", expQB.size(), 0);
            end
        end
    end

    task automatic pushFrameA();
        expQA.push_back(8'hA5);
        for (int a = 0; a <= 31; a++) begin
            expQA.push_back(8'(a));
            for (int b = 0; b < 4; b++) expQA.push_back(regsA[a][8*b +: 8]);
        end
    endtask

    task automatic pushFrameB();
        expQB.push_back(8'hA5);
        expQB.push_back(8'd5);
        for (int b = 0; b < 4; b++) expQB.push_back(regsB[5][8*b +: 8]);
    endtask

    task automatic pulseStartA();
        @(posedge clk); #1 startA = 1'b1;
        @(posedge clk); #1 startA = 1'b0;
    endtask

    task automatic waitDoneA(string name, int limit);
        int base = doneCntA;
        int c = 0;
        while (doneCntA == base && c < limit) begin
            @(negedge clk);
            c++;
        end
        chk(name, doneCntA - base, 1);
    endtask

    task automatic checkIdleA(string name);
        @(negedge clk);
        chk({name, "_busy_low"}, busyA, 0);
        chk({name, "_regAddr_first"}, ifA.regAddr, 0);
        repeat (15) @(negedge clk);
        chk({name, "_no_more_bytes"}, ifA.txValid, 0);
    endtask

    task automatic fullDumpA(string name);
        popCntA = 0;
        pushFrameA();
        pulseStartA();
        waitDoneA({name, "_done"}, 2500);
        chk({name, "_byte_count"}, popCntA, 161);
        checkIdleA(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; startA = 1'b0; startB = 1'b0; randReady = 1'b0;
        for (int i = 0; i < 32; i++) begin
            regsA[i] = {27'h0, 5'(i)} ^ 32'hDEAD0000;
            regsB[i] = $urandom;
        end
        regsA[0] = 32'h00000040;
        regsB[5] = 32'h12345678;

        #12;
        chk("rst_A_txValid", ifA.txValid, 0);
        chk("rst_A_txData", ifA.txData, 0);
        chk("rst_A_busy", busyA, 0);
        chk("rst_A_done", doneA, 0);
        chk("rst_A_regAddr", ifA.regAddr, 0);
        chk("rst_B_regAddr", ifB.regAddr, 5);
        #11 rst_n = 1'b1;

        // Fixed pattern, txReady high; also covers no wrap past 1F.
        fullDumpA("fixed");

        // Single-record instance.
        popCntB = 0;
        pushFrameB();
        @(posedge clk); #1 startB = 1'b1;
        @(posedge clk); #1 startB = 1'b0;
        begin
            int base = doneCntB;
            int c = 0;
            while (doneCntB == base && c < 100) begin @(negedge clk); c++; end
            chk("B_done", doneCntB - base, 1);
        end
        chk("B_byte_count", popCntB, 6);
        @(negedge clk);
        chk("B_busy_after", busyB, 0);

        // Random register contents under random backpressure.
        randReady = 1'b1;
        for (int r = 0; r < 2; r++) begin
            foreach (regsA[i]) regsA[i] = $urandom;
            fullDumpA("bp");
        end
        randReady = 1'b0;

        // Start pulses while busy and during DONE: one frame only.
        popCntA = 0;
        pushFrameA();
        pulseStartA();
        begin
            int c = 0;
            logic seen = 1'b0;
            while (!seen && c < 2500) begin
                @(negedge clk);
                c++;
                if (doneA) begin
                    startA = 1'b1;
                    seen = 1'b1;
                end else if (busyA) begin
                    startA = ($urandom_range(0, 7) == 0);
                end
            end
            chk("ign_done_seen", seen, 1);
        end
        @(posedge clk); #1 startA = 1'b0;
        chk("ign_byte_count", popCntA, 161);
        checkIdleA("ign");

        // Asynchronous reset mid-SEND, after byte 2 of record x7.
        popCntA = 0;
        pushFrameA();
        pulseStartA();
        begin
            int c = 0;
            while (popCntA < 39 && c < 1000) begin @(negedge clk); c++; end
            chk("rst_mid_reached", popCntA, 39);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_txValid", ifA.txValid, 0);
        chk("rst_mid_busy", busyA, 0);
        chk("rst_mid_done", doneA, 0);
        chk("rst_mid_regAddr", ifA.regAddr, 0);
        expQA.delete();
        @(negedge clk);
        #3 rst_n = 1'b1;
        fullDumpA("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr_reg_dump.md
Name: sr_reg_dump

Overview:
- Reader-side master for the CPU debug register port (regAddr out, regData in). On a start pulse it walks a range of register addresses and captures each 32-bit value.
- It streams the values as framed bytes on a valid/ready byte interface, which feeds the board UART TX or a bench monitor.
- Address 0 on the debug port returns the PC, so a full dump covers the PC plus x1..x31.
- The CPU is not stalled. Each value is sampled live, one register at a time.

Parameters:
- FIRST_REG, 0, first debug address dumped (0..31).
- LAST_REG, 31, last debug address dumped (FIRST_REG..31). FIRST_REG > LAST_REG is an elaboration error.
- SYNC_BYTE, 8'hA5, frame header byte sent before the first record.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a dump; sampled only in IDLE
- busy  output  1  high from the cycle after an accepted start until DONE
- done  output  1  one-cycle pulse after the last byte is accepted
- regAddr  output  5  debug register address to the CPU
- regData  input  32  debug register data from the CPU; combinational from regAddr
- txData  output  8  byte to transmit
- txValid  output  1  txData is valid
- txReady  input  1  sink accepts the byte this cycle

Behaviour:
- Reset is asynchronous, active-low, and applies at any time, including mid-dump. Reset values:
  - state=IDLE
  - busy=0, done=0, txValid=0
  - txData=0
  - regAddr=FIRST_REG
  - byte counter=0
- A partially sent frame is abandoned on reset; no recovery is attempted.
- Handshake: a transfer occurs when txValid && txReady. While txValid=1 and txReady=0, txData is held stable and txValid does not drop. txReady is ignored while txValid=0.
- States:
  - IDLE: start=1 -> SYNC, busy<=1, regAddr<=FIRST_REG. start=0 -> stay.
  - SYNC: txValid=1, txData=SYNC_BYTE. On transfer -> CAPTURE.
  - CAPTURE: one cycle, txValid=0. Latch shift register <= regData and addrByte <= {3'b000, regAddr}; clear byte counter -> SEND. regAddr is stable for at least one full cycle before the capture edge.
  - SEND: txValid=1. Byte 0 is addrByte; bytes 1..4 are data[7:0], [15:8], [23:16], [31:24] (LSB first). Each transfer increments the counter.
    - Transfer of byte 4 with regAddr==LAST_REG -> DONE.
    - Transfer of byte 4 otherwise -> CAPTURE, with regAddr<=regAddr+1 on that edge.
  - DONE: done=1 for exactly one cycle, busy<=0, regAddr<=FIRST_REG -> IDLE.
- Completion is decided by comparing against LAST_REG before incrementing. With LAST_REG=31 the 5-bit address never wraps to 0.
- Frame length is 1 + 5*(LAST_REG-FIRST_REG+1) bytes; the default is 161.
- Latency with txReady tied high:
  - start at edge 0 -> SYNC valid after edge 1.
  - Each record takes 1 capture cycle + 5 byte cycles.
  - The default dump completes in 1+32*6 = 193 cycles after SYNC is accepted, then DONE.
- start while busy is ignored; no queuing. start asserted in the same cycle as DONE is also ignored.
- A constant start=1 re-triggers on the first IDLE cycle after DONE.

Decomposition:
- Shared header sr_cpu.vh gains:
  - SR_DUMP_SYNC default (8'hA5)
  - state encodings SR_DUMP_IDLE, SR_DUMP_SYNC, SR_DUMP_CAPTURE, SR_DUMP_SEND, SR_DUMP_DONE (3-bit)
  - record length constant SR_DUMP_REC_BYTES=5
- One natural sub-module, sr_dump_shifter. It holds the 40-bit {data, addrByte} record register, byte counter and byte mux. Interface:
  - inputs: load, shift, regData, regAddr
  - outputs: byte, last
- The FSM and address counter stay in sr_reg_dump.

Test Plan:
- Default params, txReady=1, CPU model returns regData = {27'h0, addr} ^ 32'hDEAD0000, PC=32'h00000040:
  - expect 161 bytes: A5, then 00,40,00,00,00, then 01,01,00,AD,DE, ... ending 1F,1F,00,AD,DE.
  - done pulses once; busy is high throughout.
- FIRST_REG=5, LAST_REG=5, txReady=1, x5=32'h12345678 -> bytes A5,05,78,56,34,12; done one cycle after the last byte; busy=0 after.
- Backpressure: random txReady (~30% high) on the default dump:
  - txData never changes while txValid=1 and txReady=0.
  - byte sequence identical to the txReady=1 run; no bytes lost or duplicated.
- start pulses while busy, plus start asserted during the DONE cycle -> exactly one frame is produced; a new frame starts only on the next start in IDLE.
- Assert rst_n=0 mid-SEND (after byte 2 of record x7), without waiting for a clock edge:
  - txValid=0, busy=0, done=0, regAddr=FIRST_REG immediately.
  - after release plus a start, the frame restarts from A5.
- LAST_REG=31 boundary: after record 1F, no record 00 follows (no wrap); state returns to IDLE and regAddr=FIRST_REG.
